// File: rtl/dil_pkg.sv
// dil_pkg: shared Dilithium constants, FSM state and index types for the sampler path.
package dil_pkg;
  localparam int DATA_OUT_BITS = 64;
  localparam int N = 256;
  localparam int Q = 8380417;
  localparam int COEF_W = 23;
  localparam int CAND_W = 24;
  localparam int BUF_W = 128;
  localparam int IDX_W = $clog2(N);
  localparam int FILL_W = $clog2(BUF_W) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0] cnt_t;
endpackage

// File: rtl/rej_gearbox.sv
// rej_gearbox: 64-bit squeeze words in, 24-bit candidates out, LSB-aligned bit buffer.
module rej_gearbox
  import dil_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     run,
  input  logic                     take,
  input  logic [DATA_OUT_BITS-1:0] sq_data,
  input  logic                     sq_valid,
  output logic                     sq_ready,
  output logic                     has_cand,
  output logic [COEF_W-1:0]        cand
);
  logic [BUF_W-1:0] buf_q, buf_s, buf_n;
  logic [FILL_W-1:0] fill, fill_s, fill_n;
  logic append;
  always_comb begin
    append = run && sq_valid && !clr;
    buf_s = take ? buf_q >> CAND_W : buf_q;
    fill_s = take ? fill - FILL_W'(CAND_W) : fill;
    buf_n = append ? buf_s | (BUF_W'(sq_data) << fill_s) : buf_s;
    fill_n = append ? fill_s + FILL_W'(DATA_OUT_BITS) : fill_s;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_q <= '0;
      fill <= '0;
    end else if (clr) begin
      buf_q <= '0;
      fill <= '0;
    end else begin
      buf_q <= buf_n;
      fill <= fill_n;
    end
  // Headroom of one word covers the sponge's one-cycle ready-to-valid latency.
  assign sq_ready = run && (fill + (sq_valid ? FILL_W'(DATA_OUT_BITS) : '0) <= FILL_W'(DATA_OUT_BITS));
  assign has_cand = fill >= FILL_W'(CAND_W);
  assign cand = buf_q[COEF_W-1:0];
  assert property (@(posedge clk) disable iff (!rst_n) fill <= FILL_W'(BUF_W));
endmodule

// File: rtl/rej_ntt_sampler.sv
// rej_ntt_sampler: RejNTTPoly rejection sampler reading the SHAKE128 squeeze stream.
module rej_ntt_sampler
  import dil_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_OUT_BITS-1:0] sq_data,
  input  logic                     sq_valid,
  output logic                     sq_ready,
  output logic [COEF_W-1:0]        coef,
  output idx_t                     coef_idx,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic                     busy,
  output logic                     done
);
  state_t state, state_n;
  cnt_t cnt;
  logic run, has_cand, take, acc, hs;
  logic [COEF_W-1:0] cand;
  rej_gearbox u_gb (
    .clk(clk), .rst_n(rst_n), .clr(start), .run(run), .take(take),
    .sq_data(sq_data), .sq_valid(sq_valid), .sq_ready(sq_ready),
    .has_cand(has_cand), .cand(cand)
  );
  assign hs = coef_valid && coef_ready;
  assign take = run && has_cand && (!coef_valid || coef_ready);
  assign acc = take && (cand < COEF_W'(Q));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = start ? RUN
            : state == IDLE ? IDLE
            : state == RUN ? ((acc && cnt == cnt_t'(N - 1)) ? DRAIN : RUN)
            : (hs ? IDLE : DRAIN);
  end
  always_comb begin
    run = state == RUN;
    busy = state != IDLE;
    done = state == DRAIN && hs && !start;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      coef <= '0;
      coef_idx <= '0;
      coef_valid <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      coef_valid <= 1'b0;
    end else if (acc) begin
      coef <= cand;
      coef_idx <= idx_t'(cnt);
      coef_valid <= 1'b1;
      cnt <= cnt + 1'b1;
    end else if (hs) begin
      coef_valid <= 1'b0;
    end
endmodule

// File: tb/tb_rej_ntt_sampler.sv
// tb_rej_ntt_sampler: scoreboard bench with a latency-1 sponge model and a RejNTTPoly reference.
module tb_rej_ntt_sampler;
  import dil_pkg::*;
  logic clk = 0, rst_n = 0, start = 0, sq_valid = 0, coef_ready = 1;
  logic [63:0] sq_data = '0;
  logic sq_ready, coef_valid, busy, done;
  logic [22:0] coef;
  logic [7:0] coef_idx;
  always #5 clk = ~clk;
  rej_ntt_sampler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sq_data(sq_data), .sq_valid(sq_valid),
    .sq_ready(sq_ready), .coef(coef), .coef_idx(coef_idx), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .busy(busy), .done(done)
  );
  typedef struct packed {logic [22:0] c; logic [7:0] i;} exp_t;
  exp_t exp_q[$], nexp[$];
  logic [63:0] wq[$], nxt[$];
  logic ff = 0;
  int checks = 0, errors = 0, mon_cnt = 0, done_cnt = 0, base = 0, dbase = 0;
  int inj_req = 0, inj_ack = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sponge model: out_valid follows out_ready by one cycle.
  initial begin : drv
    logic r;
    forever begin
      @(negedge clk);
      r = sq_ready;
      @(posedge clk);
      #1;
      if (inj_req != inj_ack) begin
        sq_valid = 1; sq_data = '1; inj_ack++;
      end else if (r && ff) begin
        sq_valid = 1; sq_data = '1;
      end else if (r && wq.size() > 0) begin
        sq_valid = 1; sq_data = wq.pop_front();
      end else sq_valid = 0;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && coef_valid && coef_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_coef actual=%0d idx=%0d expected=none", coef, coef_idx);
      end else begin
        e = exp_q.pop_front();
        chk("coef", 64'(coef), 64'(e.c));
        chk("coef_idx", 64'(coef_idx), 64'(e.i));
      end
      mon_cnt++;
    end
    if (done) begin
      done_cnt++;
      chk("done_on_last_hs", {55'd0, coef_valid & coef_ready, coef_idx}, 64'h1FF);
    end
  end

  task automatic gen_model(int nw);
    logic [63:0] w[];
    logic [22:0] c;
    int k;
    w = new[nw];
    nxt.delete(); nexp.delete();
    for (int i = 0; i < nw; i++) begin
      w[i] = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      nxt.push_back(w[i]);
    end
    k = 0;
    for (int b = 0; b + 2 < nw * 8 && k < N; b += 3) begin
      c = {w[(b+2)/8][8*((b+2)%8) +: 7], w[(b+1)/8][8*((b+1)%8) +: 8], w[b/8][8*(b%8) +: 8]};
      if (c < 23'(Q)) begin
        nexp.push_back({c, 8'(k)});
        k++;
      end
    end
  endtask

  task automatic restart(input logic ffm);
    @(posedge clk); #2;
    start = 1; coef_ready = 0;
    wq = nxt; exp_q = nexp; ff = ffm;
    base = mon_cnt; dbase = done_cnt;
    @(posedge clk); #2;
    start = 0; coef_ready = 1;
  endtask

  task automatic wait_cnt(int n);
    int t;
    for (t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (mon_cnt - base >= n) break;
    end
    if (t == 4000) begin checks++; errors++; $display("FAIL timeout_cnt actual=%0d expected=%0d", mon_cnt - base, n); end
  endtask

  task automatic wait_run(input logic need_done);
    int t;
    for (t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && (!need_done || done_cnt > dbase)) break;
    end
    if (t == 4000) begin checks++; errors++; $display("FAIL timeout_run left=%0d expected=0", exp_q.size()); end
  endtask

  task automatic check_full_run(string tag);
    repeat (5) @(negedge clk);
    chk({tag, "_count"}, 64'(mon_cnt - base), 64'(N));
    chk({tag, "_done_once"}, 64'(done_cnt - dbase), 64'd1);
    chk({tag, "_sq_ready_low"}, 64'(sq_ready), 64'd0);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_coef_valid"}, 64'(coef_valid), 0);
    chk({tag, "_coef"}, 64'(coef), 0);
    chk({tag, "_coef_idx"}, 64'(coef_idx), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_sq_ready"}, 64'(sq_ready), 0);
  endtask

  initial begin
    int maxf, tog, f;
    logic pr, hv;
    logic [22:0] rc;
    logic [7:0] ri;
    repeat (2) @(posedge clk);
    #1 check_reset("rst");
    rst_n = 1;

    // Directed: Q-1 accepted, Q straddling the word boundary rejected.
    nxt = '{64'hE001_7FE0_0000_0001, 64'h0000_0000_0000_02FF};
    nexp = '{{23'd1, 8'd0}, {23'd8380416, 8'd1}, {23'd2, 8'd2}, {23'd0, 8'd3}};
    restart(0);
    wait_run(0);
    repeat (10) @(negedge clk);
    chk("dir_count", 64'(mon_cnt - base), 64'd4);

    // All-ones stream: every candidate rejected.
    nxt.delete(); nexp.delete();
    restart(1);
    maxf = 0; tog = 0; pr = sq_ready;
    repeat (120) begin
      @(negedge clk);
      if (int'(dut.u_gb.fill) > maxf) maxf = int'(dut.u_gb.fill);
      if (sq_ready != pr) tog++;
      pr = sq_ready;
    end
    chk("ff_fill_le_104", 64'(maxf <= 104), 64'd1);
    chk("ff_ready_toggles", 64'(tog > 10), 64'd1);
    chk("ff_no_valid", 64'(coef_valid), 64'd0);

    // Random stream against the reference model.
    gen_model(200);
    restart(0);
    wait_run(1);
    check_full_run("rand");

    // Downstream stall mid-stream.
    gen_model(200);
    restart(0);
    wait_cnt(50);
    @(posedge clk); #2 coef_ready = 0;
    hv = 0; rc = '0; ri = '0;
    repeat (20) begin
      @(negedge clk);
      if (coef_valid) begin
        if (hv) begin
          chk("hold_coef_stable", 64'(coef), 64'(rc));
          chk("hold_idx_stable", 64'(coef_idx), 64'(ri));
        end else begin
          hv = 1; rc = coef; ri = coef_idx;
        end
      end
      if (int'(dut.u_gb.fill) > 64) chk("hold_ready_low_when_full", 64'(sq_ready), 64'd0);
    end
    chk("hold_ready_dropped", 64'(sq_ready), 64'd0);
    @(posedge clk); #2 coef_ready = 1;
    wait_run(1);
    check_full_run("stall");

    // Restart after 100 coefficients with a fresh stream.
    gen_model(200);
    restart(0);
    wait_cnt(100);
    gen_model(200);
    restart(0);
    wait_run(1);
    check_full_run("restart");

    // Asynchronous reset mid-run.
    gen_model(200);
    restart(0);
    wait_cnt(30);
    @(posedge clk); #3 rst_n = 0;
    #1 check_reset("async_rst");
    exp_q.delete();
    @(posedge clk); #3 rst_n = 1;
    gen_model(200);
    restart(0);
    wait_run(1);
    check_full_run("post_rst");
    f = int'(dut.u_gb.fill);
    @(posedge clk); #2 inj_req++;
    repeat (4) @(negedge clk);
    chk("late_word_ignored_fill", 64'(dut.u_gb.fill), 64'(f));
    chk("late_word_no_valid", 64'(coef_valid), 64'd0);
    chk("late_word_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
